// File: rtl/approx_error_sweeper_if.sv
// Bundle between the error sweeper, its controller and the approximate circuit
// under evaluation: sweep control, the vector/result bus and the error statistics.
interface approx_error_sweeper_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3
);
    logic                    start;
    logic [N_IN-1:0]         dut_in;
    logic [N_OUT-1:0]        dut_out;
    logic                    busy;
    logic                    done;
    logic                    pass;
    logic [N_OUT-1:0]        max_err;
    logic [N_OUT+N_IN-1:0]   sum_err;
    logic [N_IN:0]           fail_count;
    logic [N_IN-1:0]         first_fail_vec;
    logic                    first_fail_valid;

    modport slave (
        input  start, dut_out,
        output dut_in, busy, done, pass, max_err, sum_err,
               fail_count, first_fail_vec, first_fail_valid
    );

    modport master (
        output start, dut_out,
        input  dut_in, busy, done, pass, max_err, sum_err,
               fail_count, first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/approx_error_sweeper.sv
// Exhaustive sweep of an approximate |a-b| circuit: drives every input vector,
// compares the returned result against the exact value and accumulates error statistics.
module approx_error_sweeper #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3,
    parameter int ET    = 4,
    parameter int LAT   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    approx_error_sweeper_if.slave  bus
);

    localparam int HALF  = N_IN / 2;
    localparam int DWM   = (N_OUT > HALF) ? N_OUT : HALF;
    localparam int SUM_W = N_OUT + N_IN;
    localparam int CNT_W = N_IN + 1;
    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [DWM-1:0] abs_diff(input logic [DWM-1:0] x,
                                                 input logic [DWM-1:0] y);
        logic signed [DWM:0] d;
        d = $signed({1'b0, x}) - $signed({1'b0, y});
        if (d < 0) d = -d;
        return d[DWM-1:0];
    endfunction

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              clr;
    logic              go_done;

    logic [N_IN-1:0]   drv_vec;
    logic              drv_vld;
    logic [N_IN-1:0]   line_tag;
    logic              line_vld;

    logic [DWM-1:0]    a_ext, b_ext, out_ext, exact_w, err_full;
    logic [N_OUT-1:0]  err_w;

    logic              cap_vld_q;
    logic [N_IN-1:0]   cap_tag_q;
    logic [N_OUT-1:0]  cap_err_q;
    logic              acc_last;

    logic [N_OUT-1:0]  max_q, max_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  fail_q, fail_d;
    logic [N_IN-1:0]   ffv_q, ffv_d;
    logic              ffval_q, ffval_d;
    logic              pass_q, pass_d;

    assign drv_vld = (state_q == SWEEP);
    assign drv_vec = drv_vld ? vec_q : '0;

    // Tag delay line: keeps the vector identity aligned with the DUT's latency
    generate
        if (LAT == 0) begin : g_no_delay
            assign line_tag = drv_vec;
            assign line_vld = drv_vld;
        end else begin : g_delay
            logic [N_IN-1:0] tag_q [LAT];
            logic [LAT-1:0]  tvld_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
                    tvld_q <= '0;
                end else begin
                    tag_q[0]  <= drv_vec;
                    tvld_q[0] <= drv_vld;
                    for (int i = 1; i < LAT; i++) begin
                        tag_q[i]  <= tag_q[i-1];
                        tvld_q[i] <= tvld_q[i-1];
                    end
                end
            end

            assign line_tag = tag_q[LAT-1];
            assign line_vld = tvld_q[LAT-1];
        end
    endgenerate

    assign a_ext    = DWM'(line_tag[HALF-1:0]);
    assign b_ext    = DWM'(line_tag[N_IN-1:HALF]);
    assign out_ext  = DWM'(bus.dut_out);
    assign exact_w  = abs_diff(a_ext, b_ext);
    assign err_full = abs_diff(out_ext, exact_w);
    assign err_w    = err_full[N_OUT-1:0];

    // Capture stage: error and tag of the vector whose result is on dut_out now
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_vld_q <= 1'b0;
            cap_tag_q <= '0;
            cap_err_q <= '0;
        end else begin
            cap_vld_q <= line_vld;
            cap_tag_q <= line_tag;
            cap_err_q <= err_w;
        end
    end

    assign acc_last = cap_vld_q && (cap_tag_q == LAST_VEC);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        go_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    clr     = 1'b1;
                    vec_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (vec_q == LAST_VEC) begin
                    vec_d   = '0;
                    state_d = DRAIN;
                end else begin
                    vec_d = vec_q + N_IN'(1);
                end
            end
            DRAIN: begin
                if (acc_last) begin
                    go_done = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Accumulate stage; pass is judged on the max that includes the final vector
    always_comb begin
        max_d   = max_q;
        sum_d   = sum_q;
        fail_d  = fail_q;
        ffv_d   = ffv_q;
        ffval_d = ffval_q;
        pass_d  = pass_q;
        if (clr) begin
            max_d   = '0;
            sum_d   = '0;
            fail_d  = '0;
            ffv_d   = '0;
            ffval_d = 1'b0;
            pass_d  = 1'b0;
        end else if (cap_vld_q) begin
            if (cap_err_q > max_q) max_d = cap_err_q;
            sum_d = sum_q + SUM_W'(cap_err_q);
            if (int'(cap_err_q) > ET) begin
                fail_d = fail_q + CNT_W'(1);
                if (!ffval_q) begin
                    ffv_d   = cap_tag_q;
                    ffval_d = 1'b1;
                end
            end
        end
        if (go_done) pass_d = (int'(max_d) <= ET);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q   <= '0;
            sum_q   <= '0;
            fail_q  <= '0;
            ffv_q   <= '0;
            ffval_q <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            max_q   <= max_d;
            sum_q   <= sum_d;
            fail_q  <= fail_d;
            ffv_q   <= ffv_d;
            ffval_q <= ffval_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.dut_in           = drv_vec;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.max_err          = max_q;
    assign bus.sum_err          = sum_q;
    assign bus.fail_count       = fail_q;
    assign bus.first_fail_vec   = ffv_q;
    assign bus.first_fail_valid = ffval_q;

endmodule

// File: tb/tb_approx_error_sweeper.sv
// Bench for approx_error_sweeper: two sweepers (LAT=0 and LAT=2) driving behavioural
// approximate circuits, with a queue-based scoreboard checked on every done pulse.
module tb_approx_error_sweeper;

    localparam int N_IN  = 4;
    localparam int N_OUT = 3;
    localparam int ET    = 4;
    localparam int NV    = 1 << N_IN;
    localparam int HALF  = N_IN / 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    approx_error_sweeper_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus_a ();
    approx_error_sweeper_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus_b ();

    approx_error_sweeper #(.N_IN(N_IN), .N_OUT(N_OUT), .ET(ET), .LAT(0)) ua (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    approx_error_sweeper #(.N_IN(N_IN), .N_OUT(N_OUT), .ET(ET), .LAT(2)) ub (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    typedef struct {
        int done_edge;
        int max_err;
        int sum_err;
        int fail_count;
        int ffv;
        int ffval;
        int pass;
        int busy;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t obs;
    exp_t expd;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   done_cnt [2] = '{0, 0};
    int   mode_a = 0;
    int   mode_b = 0;
    int   rtab [NV];
    logic [N_IN-1:0] bd1 = '0, bd2 = '0;

    function automatic int exact_of(int v);
        int a, b;
        a = v % (1 << HALF);
        b = v >> HALF;
        return (a > b) ? a - b : b - a;
    endfunction

    // Behavioural circuits under evaluation
    always_comb begin
        case (mode_a)
            0:       bus_a.dut_out = N_OUT'(exact_of(int'(bus_a.dut_in)));
            1:       bus_a.dut_out = '0;
            2:       bus_a.dut_out = 3'd7;
            default: bus_a.dut_out = N_OUT'(rtab[bus_a.dut_in]);
        endcase
    end

    always_comb begin
        if (mode_b == 4) bus_b.dut_out = N_OUT'(exact_of(int'(bd2)));
        else             bus_b.dut_out = N_OUT'(exact_of(int'(bus_b.dut_in)));
    end

    always @(posedge clk) begin
        bd1 <= bus_b.dut_in;
        bd2 <= bd1;
        cyc <= cyc + 1;
    end

    // Value the circuit presents while vector v's result is being captured
    function automatic int presented(int mode, int v);
        case (mode)
            0: return exact_of(v);
            1: return 0;
            2: return 7;
            3: return rtab[v];
            4: return exact_of(v);
            default: return (v + 2 < NV) ? exact_of(v + 2) : 0;
        endcase
    endfunction

    function automatic exp_t model(int mode, int lat, int st);
        exp_t e;
        int d;
        e = '{default: 0};
        for (int v = 0; v < NV; v++) begin
            d = presented(mode, v) - exact_of(v);
            if (d < 0) d = -d;
            if (d > e.max_err) e.max_err = d;
            e.sum_err += d;
            if (d > ET) begin
                e.fail_count++;
                if (e.ffval == 0) begin
                    e.ffv   = v;
                    e.ffval = 1;
                end
            end
        end
        e.pass      = (e.max_err <= ET) ? 1 : 0;
        e.busy      = 1;
        e.done_edge = st + NV + lat + 1;
        return e;
    endfunction

    function automatic exp_t snap(int w);
        exp_t o;
        o.done_edge = cyc;
        if (w == 0) begin
            o.max_err = int'(bus_a.max_err);    o.sum_err = int'(bus_a.sum_err);
            o.fail_count = int'(bus_a.fail_count); o.ffv = int'(bus_a.first_fail_vec);
            o.ffval = int'(bus_a.first_fail_valid); o.pass = int'(bus_a.pass);
            o.busy = int'(bus_a.busy);
        end else begin
            o.max_err = int'(bus_b.max_err);    o.sum_err = int'(bus_b.sum_err);
            o.fail_count = int'(bus_b.fail_count); o.ffv = int'(bus_b.first_fail_vec);
            o.ffval = int'(bus_b.first_fail_valid); o.pass = int'(bus_b.pass);
            o.busy = int'(bus_b.busy);
        end
        return o;
    endfunction

    function automatic int done_of(int w);
        return (w == 0) ? int'(bus_a.done) : int'(bus_b.done);
    endfunction

    function automatic int dut_in_of(int w);
        return (w == 0) ? int'(bus_a.dut_in) : int'(bus_b.dut_in);
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_res(string p, exp_t o, exp_t e, bit timing);
        if (timing) chk({p, "_done_edge"}, o.done_edge, e.done_edge);
        chk({p, "_max_err"},    o.max_err,    e.max_err);
        chk({p, "_sum_err"},    o.sum_err,    e.sum_err);
        chk({p, "_fail_count"}, o.fail_count, e.fail_count);
        chk({p, "_first_fail_vec"},   o.ffv,   e.ffv);
        chk({p, "_first_fail_valid"}, o.ffval, e.ffval);
        chk({p, "_pass"}, o.pass, e.pass);
        chk({p, "_busy"}, o.busy, e.busy);
    endtask

    task automatic set_start(int w, logic v);
        if (w == 0) bus_a.start = v;
        else        bus_b.start = v;
    endtask

    // Scoreboard monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        for (int w = 0; w < 2; w++) begin
            if (done_of(w) == 1) begin
                done_cnt[w]++;
                obs = snap(w);
                if ((w == 0 ? qa.size() : qb.size()) == 0) begin
                    chk(w == 0 ? "a_unexpected_done" : "b_unexpected_done", 1, 0);
                end else begin
                    expd = (w == 0) ? qa.pop_front() : qb.pop_front();
                    chk_res(w == 0 ? "a" : "b", obs, expd, 1'b1);
                end
            end
        end
    end

    task automatic run(int w, int mode, bit poke);
        int   st;
        int   dc0;
        bit   seen;
        exp_t e;
        string p;
        p = (w == 0) ? "a" : "b";
        if (w == 0) mode_a = mode;
        else        mode_b = mode;
        if (mode == 3)
            for (int v = 0; v < NV; v++) rtab[v] = int'($urandom_range(0, 7));
        @(negedge clk);
        st  = cyc + 1;
        dc0 = done_cnt[w];
        e   = model(mode, (w == 0) ? 0 : 2, st);
        if (w == 0) qa.push_back(e);
        else        qb.push_back(e);
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            if (poke) begin
                if (k <= NV) chk({p, "_dut_in_seq"}, dut_in_of(w), (k < NV) ? k : 0);
                set_start(w, (k == 3 || k == 9) ? 1'b1 : 1'b0);
            end
            if (done_of(w) == 1) seen = 1;
            else @(negedge clk);
        end
        if (!seen) begin
            chk({p, "_timeout"}, 0, 1);
            if (w == 0 && qa.size() > 0) void'(qa.pop_back());
            if (w == 1 && qb.size() > 0) void'(qb.pop_back());
        end else begin
            if (poke) set_start(w, 1'b1);
            @(negedge clk);
            set_start(w, 1'b0);
            chk({p, "_done_width"}, done_of(w), 0);
            chk({p, "_busy_after"}, snap(w).busy, 0);
            repeat (3) @(negedge clk);
            chk({p, "_no_restart"}, snap(w).busy, 0);
            chk({p, "_done_pulses"}, done_cnt[w] - dc0, 1);
            e.done_edge = 0;
            e.busy      = 0;
            chk_res({p, "_hold"}, snap(w), e, 1'b0);
        end
    endtask

    task automatic chk_zero(string p, int w);
        exp_t z;
        z = '{default: 0};
        chk_res(p, snap(w), z, 1'b0);
        chk({p, "_done"},   done_of(w), 0);
        chk({p, "_dut_in"}, dut_in_of(w), 0);
    endtask

    initial begin
        int st;
        rst         = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("rst_a", 0);
        chk_zero("rst_b", 1);
        rst = 1'b0;
        @(negedge clk);

        run(0, 0, 1'b0);
        run(0, 1, 1'b0);
        run(0, 2, 1'b0);
        for (int i = 0; i < 4; i++) run(0, 3, 1'b0);
        run(1, 4, 1'b0);
        run(1, 5, 1'b0);

        // Reset in the middle of a sweep that has already accumulated failures
        mode_a = 2;
        @(negedge clk);
        st = cyc + 1;
        qa.push_back(model(2, 0, st));
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        for (int k = 0; k < 20 && cyc < st + 5; k++) @(negedge clk);
        chk("mid_fail_count_before_rst", int'(bus_a.fail_count) > 0 ? 1 : 0, 1);
        #2 rst = 1'b1;
        #1 chk_zero("mid_rst_a", 0);
        void'(qa.pop_back());
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_idle_busy", int'(bus_a.busy), 0);

        run(0, 2, 1'b0);
        run(0, 3, 1'b1);
        run(1, 4, 1'b1);

        repeat (5) @(negedge clk);
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got %0d cycles", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/approx_error_sweeper.md
Name: approx_error_sweeper

Overview:
- Sequential checker that drives every input vector into an approximate combinational arithmetic circuit (abs-diff family) and reads back its outputs.
- Compares each result against the exact |a-b| and accumulates error statistics: max, sum and count of threshold violations.
- Sits beside the approximate netlist in the evaluation harness and gives a hardware pass/fail against the error threshold ET.

Parameters:
- N_IN, 4, total DUT input bits; a = dut_in[N_IN/2-1:0], b = dut_in[N_IN-1:N_IN/2]; must be even.
- N_OUT, 3, DUT output bits; dut_out interpreted unsigned, bit0 = out0.
- ET, 4, error threshold; a vector fails when err > ET.
- LAT, 0, DUT latency in cycles from dut_in change to valid dut_out; range 0..7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin sweep; sampled only in IDLE.
- dut_in  out  N_IN  vector driven to DUT.
- dut_out  in  N_OUT  DUT result.
- busy  out  1  high from the edge accepting start through the edge that raises done.
- done  out  1  one-cycle pulse when results are final.
- pass  out  1  max_err <= ET; valid from done until the next start.
- max_err  out  N_OUT  largest err seen.
- sum_err  out  N_OUT+N_IN  sum of err over all vectors.
- fail_count  out  N_IN+1  number of vectors with err > ET.
- first_fail_vec  out  N_IN  lowest failing vector.
- first_fail_valid  out  1  at least one failure recorded.

Behaviour:
- rst (async, any time, including mid-sweep): state = IDLE; all outputs = 0; vector counter, tag delay line and compare register cleared. Results are not retained.
- Exact model: exact = |a-b|, zero-extended to N_OUT. err = |dut_out - exact|, width N_OUT, with no overflow possible.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE: dut_in = 0. When start=1 at an edge (edge 0):
  - clear all accumulators, pass and first_fail_valid;
  - vec = 0, busy = 1, go to SWEEP.
- SWEEP: dut_in = vec, with vec incrementing at each edge. At the edge where vec = 2^N_IN-1, go to DRAIN and dut_in returns to 0.
- Timing: vector v is driven after edge v. Its dut_out is valid after edge v+LAT. It is captured (err plus vector tag through an LAT-deep tag delay line) at edge v+LAT+1. It is accumulated at edge v+LAT+2.
- DRAIN: waits until the last vector is accumulated at edge 2^N_IN+LAT+1. At that same edge it goes to DONE and registers done = 1 and pass.
- DONE: lasts one cycle (done high, busy high). Next edge: done = 0, busy = 0, go to IDLE. Results and pass hold until the next accepted start or rst.
- Accumulate step:
  - max_err = max(max_err, err);
  - sum_err += err;
  - if err > ET: fail_count += 1; if !first_fail_valid, capture first_fail_vec = tag and set first_fail_valid = 1.
- Capture/accumulate pipeline is enabled only for tags belonging to the current sweep. DUT outputs in IDLE/DRAIN after the last vector are ignored.
- start is ignored while busy (SWEEP/DRAIN/DONE). start held high through DONE re-triggers only once IDLE is reached, i.e. on the edge after done deasserts.
- Total for default parameters: done high in the cycle after edge 17.

Test Plan:
- Exact behavioural DUT, LAT=0, pulse start -> done after edge 17; max_err=0, sum_err=0, fail_count=0, first_fail_valid=0, pass=1.
- Constant-0 DUT -> max_err=3, sum_err=20, fail_count=0, pass=1.
- Constant-7 DUT -> max_err=7, sum_err=92, fail_count=14, first_fail_vec=0, first_fail_valid=1, pass=0.
- LAT=2 with exact DUT delayed 2 cycles -> done after edge 19; all errors 0, pass=1. Also run an undelayed exact DUT with LAT=2 -> nonzero sum_err (alignment check).
- Assert rst mid-sweep (after edge 5) -> outputs immediately 0, state IDLE. A new start then completes a clean full sweep with correct results.
- Pulse start during SWEEP and DONE -> ignored; exactly one done pulse; dut_in sequence 0..15 with no restart.
